// File: rtl/alu16_muldiv_seq_if.sv
// rtl/alu16_muldiv_seq_if.sv - request/result handshake bundle for the multiply/divide sequencer
//
// Signals:
//   start, op, opa, opb   request side: op 0 = multiply, 1 = divide; accepted when start && in_ready
//   in_ready              sequencer is idle and can accept a request
//   out_valid, out_ready  result handshake; result held until out_ready
//   res_hi, res_lo        mul: product[31:16] / product[15:0]; div: remainder / quotient
//   div_zero              divide with opb == 0, qualified by out_valid
// Modports: master = requester/consumer, slave = sequencer.
interface alu16_muldiv_seq_if;
    logic        start;
    logic        op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res_hi;
    logic [15:0] res_lo;
    logic        div_zero;

    modport master (
        output start, op, opa, opb, out_ready,
        input  in_ready, out_valid, res_hi, res_lo, div_zero
    );

    modport slave (
        input  start, op, opa, opb, out_ready,
        output in_ready, out_valid, res_hi, res_lo, div_zero
    );
endinterface

// File: rtl/alu16_muldiv_seq.sv
// rtl/alu16_muldiv_seq.sv - multi-cycle unsigned 16x16 multiply / 16/16 divide on a shared alu_16
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high; aborts any operation in flight
//   bus         alu16_muldiv_seq_if.slave request/result handshake
//   alu_aluop   to alu_16 aluop {inva, invb, ci, op[1:0]}
//   alu_a       to alu_16 a
//   alu_b       to alu_16 b
//   alu_result  from alu_16 result (combinational)
// Parameters: WIDTH (operand width, 16 only), ITERS (iterations per operation, equals WIDTH).
// Optional feature macro: MULDIV_EARLY_OUT_EN - multiply finishes early once the
// remaining multiplier bits are all zero.
module alu16_muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu16_muldiv_seq_if.slave bus,
    output logic [4:0]       alu_aluop,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01110;
    localparam logic [4:0] LAST    = 5'(ITERS - 1);

    state_t           state, state_next;
    // hi/lo: MUL partial product / multiplier; DIV remainder R / quotient-dividend Q.
    logic [WIDTH-1:0] hi, lo;
    // Multiplicand in MUL, divisor in DIV.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             div_zero;
    logic [4:0]       count;

    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH:0]   s;
    logic             y15, carry, last, early;

    assign s    = {hi, lo[WIDTH-1]};
    assign last = (count == LAST);

    // alu_16 has no carry-out; rebuild it from the sign bits of the effective operands and the sum.
    assign y15   = alu_aluop[3] ^ alu_b[WIDTH-1];
    assign carry = (alu_a[WIDTH-1] & y15) | ((alu_a[WIDTH-1] | y15) & ~alu_result[WIDTH-1]);

`ifdef MULDIV_EARLY_OUT_EN
    // Multiplier bits not yet consumed sit in lo[15-count:0].
    assign early = (state == MUL) && ((lo & ({WIDTH{1'b1}} >> count)) == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        alu_aluop  = ALU_NOP;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op)             state_next = MUL;
                    else if (bus.opb == '0)  state_next = DONE;
                    else                     state_next = DIV;
                end
            end
            MUL: begin
                alu_aluop = ALU_ADD;
                alu_a     = hi;
                alu_b     = opnd;
                if (last || early) state_next = DONE;
            end
            DIV: begin
                alu_aluop = ALU_SUB;
                alu_a     = s[WIDTH-1:0];
                alu_b     = opnd;
                if (last) state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One shift-add / restoring-subtract step per cycle.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        case (state)
            MUL: begin
`ifdef MULDIV_EARLY_OUT_EN
                if (early)
                    {hi_next, lo_next} = {hi, lo} >> (5'(WIDTH) - count);
                else
`endif
                if (lo[0])
                    {hi_next, lo_next} = {carry, alu_result, lo[WIDTH-1:1]};
                else
                    {hi_next, lo_next} = {1'b0, hi, lo[WIDTH-1:1]};
            end
            DIV: begin
                // s[16] set means the shifted remainder already exceeds any 16-bit divisor.
                if (s[WIDTH] | carry) begin
                    hi_next = alu_result;
                    lo_next = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi_next = s[WIDTH-1:0];
                    lo_next = {lo[WIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            count    <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count <= '0;
                        hi    <= '0;
                        if (!bus.op) begin
                            lo   <= bus.opb;
                            opnd <= bus.opa;
                        end else if (bus.opb != '0) begin
                            lo   <= bus.opa;
                            opnd <= bus.opb;
                        end else begin
                            res_lo   <= {WIDTH{1'b1}};
                            res_hi   <= bus.opa;
                            div_zero <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + 5'd1;
                    if (state_next == DONE) begin
                        res_hi   <= hi_next;
                        res_lo   <= lo_next;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.res_hi    = res_hi;
    assign bus.res_lo    = res_lo;
    assign bus.div_zero  = div_zero;
endmodule

// File: doc/alu16_muldiv_seq.md
Name: alu16_muldiv_seq

Overview:
- Multi-cycle sequencer that runs 16-bit unsigned multiply (32-bit product) and unsigned divide (quotient and remainder) on a single shared alu_16 instance.
- Drives the ALU's aluop/a/b inputs and reads its result combinationally.
- Holds shift/partial registers and the iteration counter.
- Sits beside the core ALU and serves multiply/divide instructions through a start/ready and valid/ready handshake.

Parameters:
- WIDTH, 16, operand width; only 16 is supported, to match alu_16.
- ITERS, 16, iteration count per operation; must equal WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; accepted when start && in_ready
- op  input  1  0 = multiply, 1 = divide
- opa  input  16  multiplicand / dividend
- opb  input  16  multiplier / divisor
- in_ready  output  1  high only in IDLE
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  consumer accepts result
- res_hi  output  16  mul: product[31:16]; div: remainder
- res_lo  output  16  mul: product[15:0]; div: quotient
- div_zero  output  1  divide with opb == 0; valid with out_valid
- alu_aluop  output  5  to alu_16 aluop {inva, invb, ci, op[1:0]}
- alu_a  output  16  to alu_16 a
- alu_b  output  16  to alu_16 b
- alu_result  input  16  from alu_16 result

Behaviour:
- Reset (synchronous, active-high; clk and rst as named above):
  - Enters IDLE; count = 0.
  - res_hi, res_lo, div_zero, out_valid = 0; in_ready = 1.
  - Reset mid-operation aborts the operation; no result is produced.
- States:
  - IDLE, MUL, DIV, DONE.
- ALU encodings:
  - ADD = 5'b00010; SUB = 5'b01110 (a + ~b + 1).
  - IDLE and DONE drive aluop = 5'b00000, a = 0, b = 0.
- Carry-out reconstruction (alu_16 exposes none):
  - c = (x15 & y15) | ((x15 | y15) & ~r15).
  - x15 = alu_a[15]; y15 = effective b[15] (inverted for SUB); r15 = alu_result[15].
- IDLE:
  - On start, latch operands and set count = 0.
  - op = 0: hi = 0, lo = opb, mcand = opa; go to MUL.
  - op = 1, opb != 0: R = 0, Q = opa, dsor = opb; go to DIV.
  - op = 1, opb == 0: res_lo = 16'hFFFF, res_hi = opa, div_zero = 1; go directly to DONE.
- MUL (one iteration per cycle):
  - alu_a = hi, alu_b = mcand, aluop = ADD.
  - If lo[0]: {hi, lo} <= {c, alu_result, lo} >> 1.
  - Else: {hi, lo} <= {1'b0, hi, lo} >> 1.
  - count++; after iteration 16, load res_hi/res_lo and go to DONE.
- DIV (restoring, one iteration per cycle):
  - s = {R, Q[15]} (17 bits).
  - alu_a = s[15:0], alu_b = dsor, aluop = SUB.
  - If s[16] | c: R <= alu_result[15:0], Q <= {Q[14:0], 1}.
  - Else: R <= s[15:0], Q <= {Q[14:0], 0}.
  - After 16 iterations: res_hi = R, res_lo = Q, div_zero = 0; go to DONE.
- DONE:
  - out_valid = 1; res_* and div_zero held stable.
  - On out_ready: go to IDLE, deassert out_valid.
  - in_ready rises the following cycle; there is no back-to-back accept.
- Latency:
  - Accept in cycle C; iterations in C+1..C+16; out_valid from C+17.
  - Divide by zero: out_valid from C+1.
- Boundary behaviour:
  - start while not IDLE: ignored; no queuing.
  - opa/opb changes after accept: no effect.
  - out_ready while out_valid is low: ignored.
  - Wrap-around is impossible: the product fits 32 bits and the quotient fits 16 bits.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - At each MUL cycle, unconsumed multiplier bits are lo[15-count:0].
  - If these are all zero: {hi, lo} <= {hi, lo} >> (16 - count) in that cycle, then go to DONE.
  - Example: multiplier 0 gives out_valid at C+2; multiplier 1 gives out_valid at C+3.
  - DIV is unaffected.
- Undefined:
  - Fixed 16-iteration multiply; no shifter logic is present.

Test Plan:
- mul 16'h1234 × 16'h5678 -> res_hi = 16'h0626, res_lo = 16'h0060, div_zero = 0, out_valid at C+17 (without the macro).
- mul 16'hFFFF × 16'hFFFF -> {res_hi, res_lo} = 32'hFFFE0001; checks the carry-reconstruction path.
- div 1000 ÷ 7 -> res_lo = 16'h008E, res_hi = 16'h0006.
- div 16'hFFFF ÷ 1 -> quotient 16'hFFFF, remainder 0.
- div 16'h1234 ÷ 0 -> div_zero = 1, res_lo = 16'hFFFF, res_hi = 16'h1234, out_valid at C+1.
- Handshake and reset:
  - out_ready held low 5 cycles -> outputs stable, in_ready = 0.
  - start pulsed mid-MUL -> ignored.
  - rst asserted at iteration 8 -> IDLE next cycle, all outputs 0, no out_valid.
  - Then run mul 3 × 5 -> 15.
  - With MULDIV_EARLY_OUT_EN: mul 16'h1234 × 1 -> 16'h00001234 at C+3.
